// File: rtl/iq_pkg.sv
// iq_pkg: shared widths and types for the instruction queue
package iq_pkg;
  localparam int INST_W   = 66;
  localparam int IQ_DEPTH = 64;
  localparam int PTR_W    = 6;
  localparam int CNT_W    = 7;
  typedef logic [INST_W-1:0] inst_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/iq_cnt4.sv
// iq_cnt4: population count of a 4-bit mask
module iq_cnt4 (
  input  logic [3:0] mask,
  output logic [2:0] cnt
);
  assign cnt = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
endmodule

// File: rtl/inst_queue.sv
// inst_queue: 64-entry circular instruction queue, 4-wide write and consume, flush realigns pointers.
// Optional same-cycle bypass of an empty queue with macro IQ_BYPASS_EN.
module inst_queue
  import iq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       fetch_vld,
  input  logic [INST_W-1:0] fetch_inst0,
  input  logic [INST_W-1:0] fetch_inst1,
  input  logic [INST_W-1:0] fetch_inst2,
  input  logic [INST_W-1:0] fetch_inst3,
  output logic             fetch_stall,
  output logic [INST_W-1:0] inst0,
  output logic [INST_W-1:0] inst1,
  output logic [INST_W-1:0] inst2,
  output logic [INST_W-1:0] inst3,
  output logic [3:0]       inst_vld,
  output logic [PTR_W-1:0] curr_pos,
  input  logic [3:0]       pr_need_inst,
  input  logic             flush,
  input  logic [PTR_W-1:0] flush_pos,
  output logic [CNT_W-1:0] count
);
  inst_t mem [IQ_DEPTH];
  inst_t fin [4];
  inst_t qout [4];
  ptr_t rd_ptr, wr_ptr;
  cnt_t cnt_q;
  logic byp;
  logic [3:0] wmask, cmask, wen;
  logic [2:0] n_wr, n_rd;
  assign fin[0] = fetch_inst0;
  assign fin[1] = fetch_inst1;
  assign fin[2] = fetch_inst2;
  assign fin[3] = fetch_inst3;
  assign fetch_stall = cnt_q > CNT_W'(60);
`ifdef IQ_BYPASS_EN
  assign byp = rst_n && !flush && cnt_q == '0;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      qout[i]     = byp ? fin[i] : mem[rd_ptr + PTR_W'(i)];
      inst_vld[i] = byp ? fetch_vld[i] : (cnt_q > CNT_W'(i));
    end
  end
  assign wmask = fetch_stall ? 4'b0 : fetch_vld;
  assign cmask = pr_need_inst & inst_vld;
  // bypassed slots that are consumed still advance wr_ptr so positions stay aligned
  assign wen = wmask & ~(byp ? cmask : 4'b0);
  iq_cnt4 u_wr (.mask(wmask), .cnt(n_wr));
  iq_cnt4 u_rd (.mask(cmask), .cnt(n_rd));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= flush_pos + PTR_W'(1);
      wr_ptr <= flush_pos + PTR_W'(1);
      cnt_q  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(n_rd);
      wr_ptr <= wr_ptr + PTR_W'(n_wr);
      cnt_q  <= cnt_q + CNT_W'(n_wr) - CNT_W'(n_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && !flush)
      for (int i = 0; i < 4; i++)
        if (wen[i]) mem[wr_ptr + PTR_W'(i)] <= fin[i];
  end
  assign inst0    = qout[0];
  assign inst1    = qout[1];
  assign inst2    = qout[2];
  assign inst3    = qout[3];
  assign curr_pos = rd_ptr;
  assign count    = cnt_q;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue
module tb_inst_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] fetch_vld = '0;
  logic [65:0] fetch_inst0 = '0, fetch_inst1 = '0, fetch_inst2 = '0, fetch_inst3 = '0;
  logic fetch_stall;
  logic [65:0] inst0, inst1, inst2, inst3;
  logic [3:0] inst_vld;
  logic [5:0] curr_pos;
  logic [3:0] pr_need_inst = '0;
  logic flush = 1'b0;
  logic [5:0] flush_pos = '0;
  logic [6:0] count;
  int n_chk = 0;
  int n_fail = 0;

  inst_queue dut (
    .clk(clk), .rst_n(rst_n), .fetch_vld(fetch_vld),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_inst2(fetch_inst2), .fetch_inst3(fetch_inst3),
    .fetch_stall(fetch_stall), .inst0(inst0), .inst1(inst1), .inst2(inst2), .inst3(inst3),
    .inst_vld(inst_vld), .curr_pos(curr_pos), .pr_need_inst(pr_need_inst),
    .flush(flush), .flush_pos(flush_pos), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    assert ((pr_need_inst & (pr_need_inst + 4'd1)) == 4'd0) else begin
      n_fail++;
      $error("FAIL pr_thermo: got %b required thermometer", pr_need_inst);
    end

  function automatic logic [65:0] d(int n);
    return {2'(n), 32'hC0DE0000 | 32'(n), 32'(n * 7 + 1)};
  endfunction

  task automatic chk(string tag, logic [65:0] obs, logic [65:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [3:0] m, int base);
    fetch_vld = m;
    fetch_inst0 = d(base);
    fetch_inst1 = d(base + 1);
    fetch_inst2 = d(base + 2);
    fetch_inst3 = d(base + 3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fetch_vld = '0;
    pr_need_inst = '0;
    flush = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", 66'(count), 66'd0);
    chk("rst_vld", 66'(inst_vld), 66'd0);
    chk("rst_stall", 66'(fetch_stall), 66'd0);
    chk("rst_pos", 66'(curr_pos), 66'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    // first 4-write
    wr(4'b1111, 0); tick();
    chk("w1_count", 66'(count), 66'd4);
    chk("w1_vld", 66'(inst_vld), 66'hf);
    chk("w1_pos", 66'(curr_pos), 66'd0);
    chk("w1_inst0", inst0, d(0));
    chk("w1_inst3", inst3, d(3));
    for (int c = 1; c < 15; c++) begin wr(4'b1111, 4 * c); tick(); end
    chk("fill60_count", 66'(count), 66'd60);
    chk("fill60_stall", 66'(fetch_stall), 66'd0);
    wr(4'b1111, 60); tick();
    chk("full_count", 66'(count), 66'd64);
    chk("full_stall", 66'(fetch_stall), 66'd1);
    wr(4'b1111, 100); tick();
    chk("drop_count", 66'(count), 66'd64);
    chk("drop_inst0", inst0, d(0));
    pr_need_inst = 4'b0011; tick();
    chk("c2_count", 66'(count), 66'd62);
    chk("c2_pos", 66'(curr_pos), 66'd2);
    chk("c2_inst0", inst0, d(2));
    chk("c2_stall", 66'(fetch_stall), 66'd1);
    pr_need_inst = 4'b0111; tick();
    chk("c3_count", 66'(count), 66'd59);
    chk("c3_pos", 66'(curr_pos), 66'd5);
    chk("c3_stall", 66'(fetch_stall), 66'd0);
    chk("c3_inst0", inst0, d(5));
    // realign to 62 and wrap
    flush = 1'b1; flush_pos = 6'd61; tick();
    chk("f61_count", 66'(count), 66'd0);
    chk("f61_pos", 66'(curr_pos), 66'd62);
    wr(4'b1111, 200); tick();
    chk("wrap_count", 66'(count), 66'd4);
    chk("wrap_inst0", inst0, d(200));
    chk("wrap_inst2", inst2, d(202));
    chk("wrap_inst3", inst3, d(203));
    pr_need_inst = 4'b0111; tick();
    chk("wrapc_pos", 66'(curr_pos), 66'd1);
    chk("wrapc_count", 66'(count), 66'd1);
    chk("wrapc_inst0", inst0, d(203));
    wr(4'b0001, 300); tick();
    chk("w1s_count", 66'(count), 66'd2);
    chk("w1s_vld", 66'(inst_vld), 66'h3);
    chk("w1s_inst1", inst1, d(300));
    pr_need_inst = 4'b1111; tick();
    chk("over_count", 66'(count), 66'd0);
    chk("over_pos", 66'(curr_pos), 66'd3);
    wr(4'b1111, 400); tick();
    wr(4'b1111, 404); tick();
    wr(4'b0011, 408); tick();
    chk("c10_count", 66'(count), 66'd10);
    wr(4'b0011, 500); pr_need_inst = 4'b0001; flush = 1'b1; flush_pos = 6'd63; tick();
    chk("fl_count", 66'(count), 66'd0);
    chk("fl_pos", 66'(curr_pos), 66'd0);
    chk("fl_vld", 66'(inst_vld), 66'd0);
    tick();
    chk("fl_idle_count", 66'(count), 66'd0);
    wr(4'b1111, 600); tick();
    chk("post_fl_count", 66'(count), 66'd4);
    chk("post_fl_pos", 66'(curr_pos), 66'd0);
    chk("post_fl_inst0", inst0, d(600));
    // asynchronous reset in the middle of a write
    wr(4'b1111, 700);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", 66'(count), 66'd0);
    chk("arst_pos", 66'(curr_pos), 66'd0);
    chk("arst_vld", 66'(inst_vld), 66'd0);
    chk("arst_stall", 66'(fetch_stall), 66'd0);
    @(posedge clk); #1;
    fetch_vld = '0; rst_n = 1'b1;
    tick();
    chk("arel_count", 66'(count), 66'd0);
    chk("arel_vld", 66'(inst_vld), 66'd0);
`ifdef IQ_BYPASS_EN
    wr(4'b0111, 800); pr_need_inst = 4'b0001; #1;
    chk("byp_inst0", inst0, d(800));
    chk("byp_vld", 66'(inst_vld), 66'h7);
    tick();
    chk("byp_count", 66'(count), 66'd2);
    chk("byp_pos", 66'(curr_pos), 66'd1);
    chk("byp_next_inst0", inst0, d(801));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: fetch_vld  input  4  per-slot valid from fetch, contiguous from bit 0.
REQ-004 SHALL have port: fetch_inst0..fetch_inst3  input  66 each  fetched instructions, slot 0 oldest.
REQ-005 SHALL have port: fetch_stall  output  1  high when free entries < 4.
REQ-006 SHALL have port: inst0..inst3  output  66 each  entries at head, head+1, head+2, head+3.
REQ-007 SHALL have port: inst_vld  output  4  per-slot valid of inst0..3, contiguous from bit 0.
REQ-008 SHALL have port: curr_pos  output  6  queue position of inst0, the head pointer.
REQ-009 SHALL have port: pr_need_inst  input  4  allocation consume mask, thermometer from bit 0.
REQ-010 SHALL have port: flush  input  1  mispredict flush.
REQ-011 SHALL have port: flush_pos  input  6  queue position of the mispredicted branch.
REQ-012 SHALL have port: count  output  7  occupied entries, 0..64.

Function
REQ-013 SHALL be a 64-entry circular buffer with 6-bit rd_ptr and wr_ptr; both wrap 63->0.
REQ-014 SHALL write all fetch_vld slots in one cycle, at wr_ptr+0..3 in slot order, only when fetch_stall=0; slots with fetch_stall=1 are dropped, and fetch holds them.
REQ-015 SHALL compute fetch_stall combinationally from registered count: fetch_stall = (count > 60).
REQ-016 SHALL set inst_vld[i] = (count > i); inst outputs with inst_vld[i]=0 are don't-care.
REQ-017 SHALL consume k = number of set bits of (pr_need_inst & inst_vld) per cycle, with rd_ptr += k mod 64.
REQ-018 SHALL treat any non-thermometer pr_need_inst as a protocol error; the bench asserts this never occurs.
REQ-019 SHALL update count each cycle to count + written - consumed; a same-cycle write and read is legal at any occupancy.
REQ-020 SHALL, on flush=1, set rd_ptr and wr_ptr to flush_pos+1 mod 64 and set count=0, so position numbering stays aligned with the branch unit.
REQ-021 SHALL give flush priority over same-cycle writes and consumes; both are discarded.
REQ-022 SHALL, without bypass, make a written entry visible on inst0..3 one cycle after it is written.
REQ-023 SHALL keep count=64 reachable only by a 4-write at count 60; fetch_stall stays 1 through 61..64.

Reset
REQ-024 SHALL, while rst_n=0, force rd_ptr=0, wr_ptr=0, count=0, inst_vld=0, fetch_stall=0, curr_pos=0.
REQ-025 SHALL not reset storage contents.
REQ-026 SHALL abort any in-flight write or flush when reset asserts mid-operation; the queue is empty on release.

Configuration
REQ-027 SHALL support macro IQ_BYPASS_EN.
REQ-028 SHALL, with IQ_BYPASS_EN defined and count=0 and flush=0, drive fetch_inst0..3 and fetch_vld directly onto inst0..3 and inst_vld in the same cycle; consumed slots are not written, and unconsumed slots are written normally.
REQ-029 SHALL, without IQ_BYPASS_EN, give a minimum write-to-output latency of 1 cycle.

Structure
REQ-030 SHALL place INST_W=66, IQ_DEPTH=64, PTR_W=6 and CNT_W=7 in shared package iq_pkg.
REQ-031 SHALL implement popcount of a 4-bit mask (written and consumed counts) in sub-module iq_cnt4, instantiated twice.

Verification
REQ-032 SHALL cover: after reset, fetch_vld=4'b1111 for one cycle -> next cycle count=4, inst_vld=4'b1111, curr_pos=0.
REQ-033 SHALL cover: 15 cycles of 4 writes with no consume -> count=60, fetch_stall=0; one more 4-write -> count=64, fetch_stall=1, and the next write is dropped.
REQ-034 SHALL cover: rd_ptr=62, count=4, pr_need_inst=4'b0111 -> next cycle curr_pos=1, count=1.
REQ-035 SHALL cover: count=10 with same-cycle fetch_vld=4'b0011 and flush=1, flush_pos=63 -> next cycle count=0, curr_pos=0, write discarded.
REQ-036 SHALL cover: count=2, pr_need_inst=4'b1111 -> only 2 consumed, count=0.
REQ-037 SHALL cover, with IQ_BYPASS_EN: empty queue, fetch_vld=4'b0111, pr_need_inst=4'b0001 -> same-cycle inst0=fetch_inst0, next cycle count=2.
